// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the digit-serial subtractor.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter must also hold NCYC itself, the finalize step after the last digit.
    function automatic int cnt_width(input int ncyc);
        return $clog2(ncyc + 1);
    endfunction

endpackage

// File: rtl/serial_subtractor_digit_subt.sv
// Combinational DIGIT-bit ripple-borrow subtractor made of two half-subtractor cells per bit.
module digit_subt
    import serial_subtractor_pkg::*;
#(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_bin,
    output logic [DIGIT-1:0] o_diff,
    output logic             o_bout
);

    logic [DIGIT:0]   w_bor;
    logic [DIGIT-1:0] w_hd;
    logic [DIGIT-1:0] w_hb;
    logic [DIGIT-1:0] w_fb;

    assign w_bor[0] = i_bin;

    genvar gi;
    generate
        for (gi = 0; gi < DIGIT; gi++) begin : g_bit
            // First cell: a - b; second cell: that partial difference minus the incoming borrow.
            assign w_hd[gi]      = i_a[gi] ^ i_b[gi];
            assign w_hb[gi]      = ~i_a[gi] & i_b[gi];
            assign o_diff[gi]    = w_hd[gi] ^ w_bor[gi];
            assign w_fb[gi]      = ~w_hd[gi] & w_bor[gi];
            assign w_bor[gi + 1] = w_hb[gi] | w_fb[gi];
        end
    endgenerate

    assign o_bout = w_bor[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor, DIGIT bits per cycle LSB first, valid/ready on both sides.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_bin,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow,
    output logic             o_ovf
);

    localparam int NCYC = WIDTH / DIGIT;
    localparam int CW   = cnt_width(NCYC);

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
            $error("serial_subtractor: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_bor;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ovf;
    logic [DIGIT-1:0] w_dig_diff;
    logic             w_dig_bout;
    logic [WIDTH-1:0] w_diff_shift;
    logic             w_fin;

    digit_subt #(.DIGIT(DIGIT)) u_digit (
        .i_a    (r_a[DIGIT-1:0]),
        .i_b    (r_b[DIGIT-1:0]),
        .i_bin  (r_bor),
        .o_diff (w_dig_diff),
        .o_bout (w_dig_bout)
    );

    // New digits enter at the top so the first (least significant) digit ends up at bit 0.
    generate
        if (NCYC == 1) begin : g_single
            assign w_diff_shift = w_dig_diff;
        end else begin : g_multi
            assign w_diff_shift = {w_dig_diff, r_diff[WIDTH-1:DIGIT]};
        end
    endgenerate

    assign w_fin = (r_cnt == CW'(NCYC));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (i_valid) w_state_next = RUN;
            RUN:     if (w_fin)   w_state_next = DONE;
            DONE:    if (i_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        o_ready = 1'b0;
        o_valid = 1'b0;
        case (r_state)
            IDLE:    o_ready = 1'b1;
            DONE:    o_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_bor   <= 1'b0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        r_a     <= i_a;
                        r_b     <= i_b;
                        r_a_msb <= i_a[WIDTH-1];
                        r_b_msb <= i_b[WIDTH-1];
                        r_bor   <= i_bin;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    if (w_fin) begin
                        // Flags are published once the whole difference is assembled.
                        r_cnt  <= '0;
                        r_bout <= r_bor;
                        r_ovf  <= (r_a_msb != r_b_msb) && (r_diff[WIDTH-1] != r_a_msb);
                    end else begin
                        r_a    <= r_a >> DIGIT;
                        r_b    <= r_b >> DIGIT;
                        r_bor  <= w_dig_bout;
                        r_diff <= w_diff_shift;
                        r_cnt  <= r_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_diff   = r_diff;
    assign o_borrow = r_bout;
    assign o_ovf    = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench: three instances (DIGIT 2, 8, 1) checked against an arithmetic reference model.
module tb_serial_subtractor;

    typedef struct {
        logic [7:0] diff;
        logic       borrow;
        logic       ovf;
        int         acc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       iv   [3];
    logic       ordy [3];
    logic [7:0] ia   [3];
    logic [7:0] ib   [3];
    logic       ibin [3];
    logic       ov   [3];
    logic       ir   [3];
    logic [7:0] od   [3];
    logic       ob   [3];
    logic       oo   [3];

    exp_t q [3][$];
    int   cyc;
    int   n_chk;
    int   n_err;
    bit   chk_rst_req;
    int   chk_idle_d;
    bit   tmo_req;
    bit   done;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            serial_subtractor #(
                .WIDTH (8),
                .DIGIT ((gi == 0) ? 2 : ((gi == 1) ? 8 : 1))
            ) u_dut (
                .i_clk    (clk),
                .i_rst    (rst),
                .i_valid  (iv[gi]),
                .o_ready  (ordy[gi]),
                .i_a      (ia[gi]),
                .i_b      (ib[gi]),
                .i_bin    (ibin[gi]),
                .o_valid  (ov[gi]),
                .i_ready  (ir[gi]),
                .o_diff   (od[gi]),
                .o_borrow (ob[gi]),
                .o_ovf    (oo[gi])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ncyc_of(input int d);
        return (d == 0) ? 4 : ((d == 1) ? 1 : 8);
    endfunction

    // Reference: plain unsigned and signed integer arithmetic.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic bin);
        exp_t e;
        int   u;
        int   s;
        u = int'(a) - int'(b) - int'(bin);
        s = int'($signed(a)) - int'($signed(b)) - int'(bin);
        e.diff   = 8'(u);
        e.borrow = (u < 0);
        e.ovf    = (s < -128) || (s > 127);
        e.acc    = 0;
        return e;
    endfunction

    function automatic exp_t mk(input logic [7:0] d, input logic b, input logic o);
        exp_t e;
        e.diff = d; e.borrow = b; e.ovf = o; e.acc = 0;
        return e;
    endfunction

    task automatic do_op(input int d, input logic [7:0] a, input logic [7:0] b, input logic bin,
                         input exp_t e, input int hold, input bit pulse);
        int n;
        n = 0;
        while (!ordy[d] && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) begin tmo_req = 1'b1; @(posedge clk); #1; tmo_req = 1'b0; return; end
        ia[d] = a; ib[d] = b; ibin[d] = bin; iv[d] = 1'b1;
        e.acc = cyc + 1;
        q[d].push_back(e);
        @(posedge clk); #1;
        iv[d] = 1'b0;
        ia[d] = 8'($urandom); ib[d] = 8'($urandom); ibin[d] = 1'($urandom);
        n = 0;
        while (!ov[d] && n < 200) begin
            if (pulse) begin iv[d] = 1'($urandom); ir[d] = 1'($urandom); end
            @(posedge clk); #1;
            n++;
        end
        iv[d] = 1'b0;
        ir[d] = 1'b0;
        if (n >= 200) begin tmo_req = 1'b1; @(posedge clk); #1; tmo_req = 1'b0; return; end
        for (int h = 0; h < hold; h++) begin
            if (pulse) begin ia[d] = 8'($urandom); iv[d] = 1'b1; end
            @(posedge clk); #1;
        end
        iv[d] = 1'b0;
        ir[d] = 1'b1;
        @(posedge clk); #1;
        ir[d] = 1'b0;
        chk_idle_d = d;
        @(posedge clk); #1;
        chk_idle_d = -1;
    endtask

    logic [7:0] dir_a   [5] = '{8'h35, 8'h00, 8'h80, 8'h10, 8'h00};
    logic [7:0] dir_b   [5] = '{8'h12, 8'h01, 8'h01, 8'h0F, 8'h00};
    logic       dir_bin [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] dir_d   [5] = '{8'h23, 8'hFF, 8'h7F, 8'h00, 8'hFF};
    logic       dir_bo  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic       dir_ov  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    // Stimulus
    initial begin
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        int         nops;
        chk_rst_req = 1'b0; chk_idle_d = -1; tmo_req = 1'b0; done = 1'b0;
        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b0; ir[d] = 1'b0; ia[d] = '0; ib[d] = '0; ibin[d] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_rst_req = 1'b1;
        @(posedge clk); #1;
        chk_rst_req = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 5; i++)
            do_op(0, dir_a[i], dir_b[i], dir_bin[i], mk(dir_d[i], dir_bo[i], dir_ov[i]), 0, 1'b0);

        // Backpressure with ignored valid/ready pulses, then a normal op
        do_op(0, 8'hC3, 8'h5A, 1'b1, model(8'hC3, 8'h5A, 1'b1), 3, 1'b1);
        do_op(0, 8'h35, 8'h12, 1'b0, mk(8'h23, 1'b0, 1'b0), 0, 1'b0);

        // Reset during RUN cycle 2: no result may appear
        ia[0] = 8'hAA; ib[0] = 8'h11; ibin[0] = 1'b1; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_rst_req = 1'b1;
        @(posedge clk); #1;
        chk_rst_req = 1'b0;
        do_op(0, 8'h35, 8'h12, 1'b0, mk(8'h23, 1'b0, 1'b0), 0, 1'b0);

        for (int d = 0; d < 3; d++) begin
            nops = (d == 0) ? 200 : 1000;
            for (int n = 0; n < nops; n++) begin
                a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
                do_op(d, a, b, bin, model(a, b, bin), $urandom_range(0, 2), 1'($urandom));
            end
        end
        done = 1'b1;
    end

    // Monitor / scoreboard
    initial begin
        exp_t       e;
        logic       prev_v [3];
        logic [7:0] h_d    [3];
        logic       h_b    [3];
        logic       h_o    [3];
        int         lat;
        n_chk = 0; n_err = 0;
        for (int d = 0; d < 3; d++) begin prev_v[d] = 1'b0; h_d[d] = '0; h_b[d] = 1'b0; h_o[d] = 1'b0; end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (ov[d]) begin
                    n_chk++;
                    if (ordy[d]) begin
                        n_err++;
                        $display("FAIL ready_valid dut%0d: o_ready=%0b while o_valid, want 0", d, ordy[d]);
                    end
                    if (!prev_v[d]) begin
                        h_d[d] = od[d]; h_b[d] = ob[d]; h_o[d] = oo[d];
                        n_chk++;
                        if (q[d].size() == 0) begin
                            n_err++;
                            $display("FAIL unexpected_valid dut%0d: got diff=%h, want no result", d, od[d]);
                        end else begin
                            e = q[d].pop_front();
                            lat = cyc - e.acc;
                            $display("dut%0d result diff=%h borrow=%0b ovf=%0b latency=%0d", d, od[d], ob[d], oo[d], lat);
                            if (od[d] !== e.diff || ob[d] !== e.borrow || oo[d] !== e.ovf) begin
                                n_err++;
                                $display("FAIL result dut%0d: got diff=%h b=%0b v=%0b, want diff=%h b=%0b v=%0b",
                                         d, od[d], ob[d], oo[d], e.diff, e.borrow, e.ovf);
                            end
                            n_chk++;
                            if (lat != ncyc_of(d) + 1) begin
                                n_err++;
                                $display("FAIL latency dut%0d: got %0d, want %0d", d, lat, ncyc_of(d) + 1);
                            end
                        end
                    end else begin
                        n_chk++;
                        if (od[d] !== h_d[d] || ob[d] !== h_b[d] || oo[d] !== h_o[d]) begin
                            n_err++;
                            $display("FAIL hold dut%0d: got diff=%h b=%0b v=%0b, want diff=%h b=%0b v=%0b",
                                     d, od[d], ob[d], oo[d], h_d[d], h_b[d], h_o[d]);
                        end
                    end
                end
                prev_v[d] = ov[d];
            end
            if (chk_rst_req) begin
                for (int d = 0; d < 3; d++) begin
                    n_chk++;
                    if (ordy[d] !== 1'b1 || ov[d] !== 1'b0 || od[d] !== 8'h00 || ob[d] !== 1'b0 || oo[d] !== 1'b0) begin
                        n_err++;
                        $display("FAIL reset_state dut%0d: got rdy=%0b vld=%0b diff=%h b=%0b v=%0b, want 1 0 00 0 0",
                                 d, ordy[d], ov[d], od[d], ob[d], oo[d]);
                    end
                end
            end
            if (chk_idle_d >= 0) begin
                n_chk++;
                if (ordy[chk_idle_d] !== 1'b1 || ov[chk_idle_d] !== 1'b0 || od[chk_idle_d] !== h_d[chk_idle_d]
                    || ob[chk_idle_d] !== h_b[chk_idle_d] || oo[chk_idle_d] !== h_o[chk_idle_d]) begin
                    n_err++;
                    $display("FAIL post_handshake dut%0d: got rdy=%0b vld=%0b diff=%h, want 1 0 %h",
                             chk_idle_d, ordy[chk_idle_d], ov[chk_idle_d], od[chk_idle_d], h_d[chk_idle_d]);
                end
            end
            if (tmo_req) begin
                n_chk++;
                n_err++;
                $display("FAIL timeout: handshake did not occur within 200 cycles, want it to");
            end
            if (done || cyc > 90000) begin
                if (!done) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL watchdog: cycle %0d reached, want completion earlier", cyc);
                end
                for (int d = 0; d < 3; d++) begin
                    n_chk++;
                    if (q[d].size() != 0) begin
                        n_err++;
                        $display("FAIL missing_results dut%0d: %0d outstanding, want 0", d, q[d].size());
                    end
                end
                $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
                $finish;
            end
        end
    end

endmodule
